// File: rtl/maxpool_pkg.sv
// maxpool_pkg: shared FSM states, window tap count and tap index type
package maxpool_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, EMIT, DONE} state_t;
  localparam int WIN_TAPS = 4;
  typedef logic [1:0] tap_t;
endpackage

// File: rtl/pool_max_lane.sv
// pool_max_lane: per-channel signed running max over one 2x2 window; MAXPOOL_RELU_EN clamps negative maxima to 0
module pool_max_lane #(
  parameter int D_WID = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_vld,
  input  logic             i_first,
  input  logic [D_WID-1:0] i_din,
  output logic [D_WID-1:0] o_data
);
  logic [D_WID-1:0] r_acc;
  // first tap loads, later taps replace only when strictly greater (signed)
  always_ff @(posedge clk)
    if (rst) r_acc <= '0;
    else if (i_vld && (i_first || $signed(i_din) > $signed(r_acc))) r_acc <= i_din;
`ifdef MAXPOOL_RELU_EN
  assign o_data = r_acc[D_WID-1] ? '0 : r_acc;
`else
  assign o_data = r_acc;
`endif
endmodule

// File: rtl/maxpool_bank_reader.sv
// maxpool_bank_reader: walks 2x2 stride-2 windows over banked RAM port B and streams per-channel maxima (MAXPOOL_RELU_EN enables ReLU)
module maxpool_bank_reader
  import maxpool_pkg::*;
#(
  parameter int NUM_RAMS = 128,
  parameter int A_WID    = 10,
  parameter int D_WID    = 32,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_RAMS-1:0]             enb,
  output logic [NUM_RAMS-1:0]             web,
  output logic [NUM_RAMS-1:0][A_WID-1:0]  addrb,
  output logic [NUM_RAMS-1:0][D_WID-1:0]  dinb,
  input  logic [NUM_RAMS-1:0][D_WID-1:0]  doutb,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_RAMS-1:0][D_WID-1:0]  out_data,
  output logic                            out_last
);
  state_t r_state, w_next;
  tap_t r_tap;
  logic [A_WID-1:0] r_row, r_col, w_prow, w_pcol, w_addr;
  logic r_rd_vld, r_rd_first;
  logic w_issue, w_emit, w_hs, w_col_end, w_last_win;
  logic [NUM_RAMS-1:0][D_WID-1:0] w_lane;
  assign w_issue    = r_state == ISSUE;
  assign w_emit     = r_state == EMIT;
  assign w_hs       = w_emit && out_ready;
  assign w_col_end  = r_col == A_WID'(IMG_W - 2);
  assign w_last_win = w_col_end && r_row == A_WID'(IMG_H - 2);
  assign w_prow     = r_row | A_WID'(r_tap[1]);
  assign w_pcol     = r_col | A_WID'(r_tap[0]);
  assign w_addr     = w_prow * A_WID'(IMG_W) + w_pcol;
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE;
  assign enb        = {NUM_RAMS{w_issue}};
  assign web        = '0;
  assign dinb       = '0;
  assign addrb      = {NUM_RAMS{w_issue ? w_addr : {A_WID{1'b0}}}};
  assign out_valid  = w_emit;
  assign out_last   = w_emit && w_last_win;
  assign out_data   = w_lane;
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next-state: four read taps, one drain cycle for the last datum, then hold in EMIT until accepted
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? ISSUE : IDLE;
      ISSUE:   w_next = r_tap == tap_t'(WIN_TAPS - 1) ? DRAIN : ISSUE;
      DRAIN:   w_next = EMIT;
      EMIT:    w_next = w_hs ? (w_last_win ? DONE : ISSUE) : EMIT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // tap counter, read-return tracking and row-major window indices (pixel coords of window corner)
  always_ff @(posedge clk)
    if (rst) begin
      r_tap      <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_first <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      r_tap      <= w_issue ? r_tap + tap_t'(1) : '0;
      r_rd_vld   <= w_issue;
      r_rd_first <= w_issue && r_tap == '0;
      if (w_hs) begin
        r_col <= w_col_end ? '0 : r_col + A_WID'(2);
        r_row <= w_last_win ? '0 : w_col_end ? r_row + A_WID'(2) : r_row;
      end
    end
  for (genvar i = 0; i < NUM_RAMS; i++) begin : g_lane
    pool_max_lane #(.D_WID(D_WID)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_vld   (r_rd_vld),
      .i_first (r_rd_first),
      .i_din   (doutb[i]),
      .o_data  (w_lane[i])
    );
  end
endmodule
